// File: rtl/meta_pack_queue.sv
// L2 metadata packager: captures at most one record per frame and queues it in a
// DEPTH-entry first-word-fall-through FIFO with a valid/ready output and a saturating drop counter.
module meta_pack_queue #(
    parameter int DEPTH       = 4,
    parameter int EMIT_AT_END = 0,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic [47:0]              dest_mac,
    input  logic [47:0]              src_mac,
    input  logic [15:0]              resolved_ethertype,
    input  logic                     vlan_present,
    input  logic [11:0]              vlan_id,
    input  logic [4:0]               l2_header_len,
    input  logic                     proto_valid,
    input  logic                     is_ipv4,
    input  logic                     is_ipv6,
    input  logic                     is_arp,
    input  logic                     is_unknown,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [47:0]              m_dest_mac,
    output logic [47:0]              m_src_mac,
    output logic [15:0]              m_ethertype,
    output logic                     m_vlan_present,
    output logic [11:0]              m_vlan_id,
    output logic [4:0]               m_l2_header_len,
    output logic [3:0]               m_proto,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic        vlan_pres;
        logic [11:0] vlan_id;
        logic [4:0]  hdr_len;
        logic [3:0]  proto;
    } rec_t;

    rec_t          in_rec, stage_rec, push_rec, head;
    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          in_frame, captured, staged;
    logic          accept, push, pop, full, wr_en, drop;

    always_comb begin
        in_rec.dest      = dest_mac;
        in_rec.src       = src_mac;
        in_rec.etype     = resolved_ethertype;
        in_rec.vlan_pres = vlan_present;
        in_rec.vlan_id   = vlan_id;
        in_rec.hdr_len   = l2_header_len;
        in_rec.proto     = {is_unknown, is_arp, is_ipv6, is_ipv4};

        // A frame_start in this cycle opens a fresh frame, so capture is allowed regardless of captured.
        accept   = proto_valid && (frame_start || (in_frame && !captured));
        push     = 1'b0;
        push_rec = in_rec;
        if (EMIT_AT_END == 0) begin
            push = accept;
        end else if (frame_end) begin
            // With a coincident frame_start, frame_end closes the old frame; a new accept goes to staging.
            if (staged) begin
                push     = 1'b1;
                push_rec = stage_rec;
            end else if (accept && !frame_start) begin
                push = 1'b1;
            end
        end

        pop   = (level != '0) && m_ready;
        full  = (level == LW'(DEPTH));
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame  <= 1'b0;
            captured  <= 1'b0;
            staged    <= 1'b0;
            stage_rec <= '0;
        end else begin
            if (frame_start) begin
                in_frame <= 1'b1;
                captured <= accept;
            end else begin
                if (frame_end) in_frame <= 1'b0;
                if (accept)    captured <= 1'b1;
            end
            if (EMIT_AT_END != 0) begin
                // frame_start discards any staged record of an aborted frame.
                if (frame_start)    staged <= accept;
                else if (frame_end) staged <= 1'b0;
                else if (accept)    staged <= 1'b1;
            end
            if (accept) stage_rec <= in_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      level <= level + LW'(1);
            else if (pop && !wr_en) level <= level - LW'(1);
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    // Fields are forced to zero while empty so stale or uninitialised storage never shows.
    always_comb begin
        m_valid         = (level != '0);
        head            = m_valid ? mem[rd_ptr] : '0;
        m_dest_mac      = head.dest;
        m_src_mac       = head.src;
        m_ethertype     = head.etype;
        m_vlan_present  = head.vlan_pres;
        m_vlan_id       = head.vlan_id;
        m_l2_header_len = head.hdr_len;
        m_proto         = head.proto;
    end
endmodule

// File: tb/tb_meta_pack_queue.sv
// Directed bench: one instance per emit mode sharing stimulus, checked against hand-computed values.
module tb_meta_pack_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start, frame_end, proto_valid, m_ready;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] resolved_ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [4:0]  l2_header_len;
    logic        is_ipv4, is_ipv6, is_arp, is_unknown;

    logic        v0, v1, vp0, vp1;
    logic [47:0] d0, d1, s0, s1;
    logic [15:0] e0, e1;
    logic [11:0] vid0, vid1;
    logic [4:0]  hl0, hl1;
    logic [3:0]  p0, p1;
    logic [2:0]  lv0, lv1;
    logic [15:0] dc0, dc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    meta_pack_queue #(.DEPTH(4), .EMIT_AT_END(0), .DROP_CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .dest_mac(dest_mac), .src_mac(src_mac), .resolved_ethertype(resolved_ethertype),
        .vlan_present(vlan_present), .vlan_id(vlan_id), .l2_header_len(l2_header_len),
        .proto_valid(proto_valid), .is_ipv4(is_ipv4), .is_ipv6(is_ipv6), .is_arp(is_arp),
        .is_unknown(is_unknown), .m_valid(v0), .m_ready(m_ready), .m_dest_mac(d0),
        .m_src_mac(s0), .m_ethertype(e0), .m_vlan_present(vp0), .m_vlan_id(vid0),
        .m_l2_header_len(hl0), .m_proto(p0), .level(lv0), .drop_cnt(dc0));

    meta_pack_queue #(.DEPTH(4), .EMIT_AT_END(1), .DROP_CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .dest_mac(dest_mac), .src_mac(src_mac), .resolved_ethertype(resolved_ethertype),
        .vlan_present(vlan_present), .vlan_id(vlan_id), .l2_header_len(l2_header_len),
        .proto_valid(proto_valid), .is_ipv4(is_ipv4), .is_ipv6(is_ipv6), .is_arp(is_arp),
        .is_unknown(is_unknown), .m_valid(v1), .m_ready(m_ready), .m_dest_mac(d1),
        .m_src_mac(s1), .m_ethertype(e1), .m_vlan_present(vp1), .m_vlan_id(vid1),
        .m_l2_header_len(hl1), .m_proto(p1), .level(lv1), .drop_cnt(dc1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        frame_start = 0; frame_end = 0; proto_valid = 0;
        dest_mac = '0; src_mac = '0; resolved_ethertype = '0;
        vlan_present = 0; vlan_id = '0; l2_header_len = '0;
        is_ipv4 = 0; is_ipv6 = 0; is_arp = 0; is_unknown = 0;
    endtask

    task automatic ipv4_rec(input logic [47:0] d);
        proto_valid = 1; dest_mac = d; src_mac = 48'h0011_2233_4455;
        resolved_ethertype = 16'h0800; l2_header_len = 5'd14; is_ipv4 = 1;
    endtask

    task automatic test_reset();
        idle(); m_ready = 0;
        #1 rst = 1;
        #1;
        total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL reset_valid got %b/%b want 0/0", v0, v1); end
        total++; if (lv0 !== 3'd0 || lv1 !== 3'd0) begin bad++; $display("FAIL reset_level got %0d/%0d want 0/0", lv0, lv1); end
        total++; if (dc0 !== 16'd0 || d0 !== 48'd0) begin bad++; $display("FAIL reset_out got drop=%0d dest=%h want 0/0", dc0, d0); end
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_basic();
        frame_start = 1; tick();
        idle(); ipv4_rec(48'hAABB_CCDD_EEFF); tick();
        total++; if (v0 !== 1'b1 || d0 !== 48'hAABB_CCDD_EEFF) begin bad++; $display("FAIL basic_head got v=%b dest=%h want 1 aabbccddeeff", v0, d0); end
        total++; if (p0 !== 4'b0001 || lv0 !== 3'd1 || e0 !== 16'h0800) begin bad++; $display("FAIL basic_fields got proto=%b lvl=%0d et=%h want 0001 1 0800", p0, lv0, e0); end
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL basic_m1_staged got v=%b want 0", v1); end
        ipv4_rec(48'h1111_2222_3333); tick();
        total++; if (lv0 !== 3'd1 || d0 !== 48'hAABB_CCDD_EEFF) begin bad++; $display("FAIL basic_repeat got lvl=%0d dest=%h want 1 aabbccddeeff", lv0, d0); end
        idle(); frame_end = 1; tick();
        total++; if (lv1 !== 3'd1 || d1 !== 48'hAABB_CCDD_EEFF) begin bad++; $display("FAIL basic_m1_end got lvl=%0d dest=%h want 1 aabbccddeeff", lv1, d1); end
        idle(); m_ready = 1; tick();
        m_ready = 0;
        total++; if (lv0 !== 3'd0 || lv1 !== 3'd0) begin bad++; $display("FAIL basic_drain got %0d/%0d want 0/0", lv0, lv1); end
    endtask

    task automatic test_overflow();
        m_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(); frame_start = 1; ipv4_rec(48'h1000 + 48'(i)); tick();
            idle(); frame_end = 1; tick();
        end
        idle();
        total++; if (lv0 !== 3'd4 || dc0 !== 16'd2) begin bad++; $display("FAIL ovf_m0 got lvl=%0d drop=%0d want 4 2", lv0, dc0); end
        total++; if (lv1 !== 3'd4 || dc1 !== 16'd2) begin bad++; $display("FAIL ovf_m1 got lvl=%0d drop=%0d want 4 2", lv1, dc1); end
        m_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (v0 !== 1'b1 || d0 !== 48'h1000 + 48'(i) || d1 !== 48'h1000 + 48'(i)) begin
                bad++; $display("FAIL ovf_order%0d got %h/%h want %h", i, d0, d1, 48'h1000 + 48'(i)); end
            tick();
        end
        m_ready = 0;
        total++; if (v0 !== 1'b0 || lv0 !== 3'd0 || lv1 !== 3'd0) begin bad++; $display("FAIL ovf_empty got v=%b lvl=%0d/%0d want 0 0/0", v0, lv0, lv1); end
    endtask

    task automatic test_full_pushpop();
        m_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            idle(); frame_start = 1; ipv4_rec(48'h2000 + 48'(i)); tick();
            idle(); frame_end = 1; tick();
        end
        idle(); frame_start = 1; ipv4_rec(48'h2005); m_ready = 1; tick();
        total++; if (lv0 !== 3'd4 || dc0 !== 16'd2 || d0 !== 48'h2002) begin bad++; $display("FAIL full_pp_m0 got lvl=%0d drop=%0d dest=%h want 4 2 2002", lv0, dc0, d0); end
        total++; if (lv1 !== 3'd3) begin bad++; $display("FAIL full_pp_m1 got lvl=%0d want 3", lv1); end
        idle(); m_ready = 0; frame_end = 1; tick();
        total++; if (lv1 !== 3'd4 || dc1 !== 16'd2) begin bad++; $display("FAIL full_pp_m1end got lvl=%0d drop=%0d want 4 2", lv1, dc1); end
        idle(); m_ready = 1;
        for (int i = 2; i <= 5; i++) begin
            total++; if (d0 !== 48'h2000 + 48'(i) || d1 !== 48'h2000 + 48'(i)) begin
                bad++; $display("FAIL full_pp_order%0d got %h/%h want %h", i, d0, d1, 48'h2000 + 48'(i)); end
            tick();
        end
        m_ready = 0;
        total++; if (lv0 !== 3'd0 || lv1 !== 3'd0) begin bad++; $display("FAIL full_pp_empty got %0d/%0d want 0/0", lv0, lv1); end
    endtask

    task automatic test_mode1_arp();
        idle(); frame_start = 1; tick();
        idle(); proto_valid = 1; dest_mac = 48'hFFFF_FFFF_FFFF; resolved_ethertype = 16'h0806;
        vlan_present = 1; vlan_id = 12'h064; l2_header_len = 5'd18; is_arp = 1; tick();
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL arp_early got v=%b want 0", v1); end
        idle(); tick();
        total++; if (v1 !== 1'b0) begin bad++; $display("FAIL arp_hold got v=%b want 0", v1); end
        frame_end = 1; tick();
        total++; if (v1 !== 1'b1 || p1 !== 4'b0100 || vid1 !== 12'h064) begin bad++; $display("FAIL arp_rec got v=%b proto=%b vid=%h want 1 0100 064", v1, p1, vid1); end
        total++; if (hl1 !== 5'd18 || e1 !== 16'h0806 || vp1 !== 1'b1) begin bad++; $display("FAIL arp_hdr got len=%0d et=%h vp=%b want 18 0806 1", hl1, e1, vp1); end
        idle(); m_ready = 1; tick();
        m_ready = 0; frame_start = 1; tick();
        idle(); frame_end = 1; tick();
        idle(); tick();
        total++; if (lv1 !== 3'd0 || lv0 !== 3'd0) begin bad++; $display("FAIL arp_noproto got %0d/%0d want 0/0", lv0, lv1); end
    endtask

    task automatic test_abort_coincide();
        idle(); frame_start = 1; tick();
        idle(); ipv4_rec(48'h5001); tick();
        idle(); frame_start = 1; tick();
        idle(); frame_end = 1; tick();
        total++; if (lv1 !== 3'd0) begin bad++; $display("FAIL abort got lvl=%0d want 0", lv1); end
        idle(); frame_start = 1; frame_end = 1; tick();
        total++; if (lv1 !== 3'd0) begin bad++; $display("FAIL coinc_open got lvl=%0d want 0", lv1); end
        idle(); ipv4_rec(48'h5002); tick();
        idle(); frame_end = 1; tick();
        idle(); tick();
        total++; if (lv1 !== 3'd1 || d1 !== 48'h5002) begin bad++; $display("FAIL coinc_one got lvl=%0d dest=%h want 1 5002", lv1, d1); end
        total++; if (lv0 !== 3'd2 || d0 !== 48'h5001) begin bad++; $display("FAIL coinc_m0 got lvl=%0d dest=%h want 2 5001", lv0, d0); end
        m_ready = 1; tick(); tick(); tick();
        m_ready = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) begin
            idle(); frame_start = 1; ipv4_rec(48'h3000 + 48'(i)); tick();
            idle(); frame_end = 1; tick();
        end
        idle(); frame_start = 1; ipv4_rec(48'h3004); tick();
        idle();
        total++; if (lv0 !== 3'd4 || lv1 !== 3'd3 || dc1 !== 16'd2) begin bad++; $display("FAIL rst_pre got %0d/%0d drop=%0d want 4/3 2", lv0, lv1, dc1); end
        #2 rst = 1;
        #1;
        total++; if (v0 !== 1'b0 || v1 !== 1'b0 || lv0 !== 3'd0 || lv1 !== 3'd0) begin bad++; $display("FAIL rst_async got v=%b/%b lvl=%0d/%0d want 0", v0, v1, lv0, lv1); end
        total++; if (dc0 !== 16'd0 || dc1 !== 16'd0) begin bad++; $display("FAIL rst_drop got %0d/%0d want 0/0", dc0, dc1); end
        #1 rst = 0;
        frame_end = 1; tick();
        total++; if (lv1 !== 3'd0) begin bad++; $display("FAIL rst_staged got lvl=%0d want 0", lv1); end
        idle(); frame_start = 1; ipv4_rec(48'h4001); tick();
        total++; if (lv0 !== 3'd1 || d0 !== 48'h4001) begin bad++; $display("FAIL rst_after_m0 got lvl=%0d dest=%h want 1 4001", lv0, d0); end
        idle(); frame_end = 1; tick();
        total++; if (lv1 !== 3'd1 || d1 !== 48'h4001) begin bad++; $display("FAIL rst_after_m1 got lvl=%0d dest=%h want 1 4001", lv1, d1); end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_mode1_arp();
        test_abort_coincide();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/meta_pack_queue.md
Name: meta_pack_queue

Overview:
- Parametrised successor to the single-shot metadata packager.
- Captures one L2 metadata record per frame, either at protocol resolution or at frame end (selectable).
- Buffers records in an internal DEPTH-entry FIFO and presents them downstream on a valid/ready interface.
- Sits between the protocol classifier and the downstream lookup/forwarding stage; absorbs backpressure and counts overflow drops.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- EMIT_AT_END, 0, 0 = push on first proto_valid in frame; 1 = stage on first proto_valid, push at frame_end.
- DROP_CNT_W, 16, width of saturating drop counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  first-beat pulse of a frame.
- frame_end  in  1  last-beat pulse of a frame.
- dest_mac  in  48  parsed destination MAC.
- src_mac  in  48  parsed source MAC.
- resolved_ethertype  in  16  ethertype after VLAN stripping.
- vlan_present  in  1  802.1Q tag seen.
- vlan_id  in  12  VLAN ID, valid when vlan_present.
- l2_header_len  in  5  L2 header bytes (14 or 18).
- proto_valid  in  1  classifier result valid this cycle.
- is_ipv4 / is_ipv6 / is_arp / is_unknown  in  1 each  one-hot protocol class.
- m_valid  out  1  head record valid.
- m_ready  in  1  downstream accepts head.
- m_dest_mac  out  48  head record field.
- m_src_mac  out  48  head record field.
- m_ethertype  out  16  head record field.
- m_vlan_present  out  1  head record field.
- m_vlan_id  out  12  head record field.
- m_l2_header_len  out  5  head record field.
- m_proto  out  4  {is_unknown,is_arp,is_ipv6,is_ipv4}, as sampled.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  DROP_CNT_W  records lost to FIFO full; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FIFO empty; in_frame = 0, captured = 0, staged = 0.
  - Reset mid-operation discards FIFO contents and any staged record.
- Frame tracking:
  - frame_start sets in_frame and clears captured.
  - frame_end clears in_frame.
  - frame_start and frame_end in the same cycle: close the current frame first, then open a new one (in_frame = 1 after).
  - frame_start while already in_frame: aborts the open frame; staged record (mode 1) is discarded, no push.
- Capture:
  - Only the first proto_valid while in_frame (or in the same cycle as frame_start) with captured = 0 is accepted; it sets captured.
  - proto_valid outside a frame, or repeated within a frame, is ignored: exactly one record per frame maximum.
  - All record fields are sampled in the accepting cycle.
- Mode 0 (EMIT_AT_END = 0): push at the accepting edge; m_valid is high in the cycle after the edge that sampled proto_valid when the FIFO was empty (1-cycle latency).
- Mode 1 (EMIT_AT_END = 1):
  - Record held in a staging register.
  - Push occurs at the frame_end edge if staged; staged then clears.
  - frame_end without a prior proto_valid pushes nothing.
  - proto_valid coincident with frame_end is accepted and pushed at that same edge.
- FIFO:
  - First-word-fall-through: m_* fields always reflect the head entry.
  - Pop on m_valid && m_ready.
  - m_valid = (level != 0). m_* fields are stable while m_valid && !m_ready.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Full boundary:
  - Push with level == DEPTH and no pop in the same cycle: record dropped, drop_cnt += 1 (saturating); FIFO unchanged.
  - Push and pop in the same cycle while full: push accepted, level stays DEPTH, no drop.
- Empty boundary: m_ready while empty has no effect. A push into an empty FIFO is not visible on m_valid until the next cycle; there is no combinational bypass.
- level: +1 on push-only, -1 on pop-only, unchanged on both or neither.

Test Plan:
- Mode 0, DEPTH=4: reset, then frame_start; next cycle proto_valid with dest=AABBCCDDEEFF, ethertype=0800, is_ipv4. Expect m_valid=1 after that edge with m_dest_mac=AABBCCDDEEFF, m_proto=4'b0001, level=1. A second proto_valid in the same frame leaves level=1.
- Mode 0, m_ready=0: 6 frames, each with proto_valid. Expect level=4, drop_cnt=2. Raise m_ready: 4 records drain in order (frames 1-4), then m_valid=0, level=0.
- Mode 0, FIFO full with m_ready=1 and a new push in the same cycle: no drop, level stays 4, drop_cnt unchanged.
- Mode 1: frame with proto_valid (ARP, ethertype 0806, vlan_id=0x064, vlan_present=1), m_valid remains 0 until the frame_end edge. After frame_end, m_proto=4'b0100, m_vlan_id=0x064, m_l2_header_len=18. A frame with no proto_valid yields no record.
- Mode 1, abort and coincidence: frame_start, proto_valid, frame_start again (abort), frame_end: no record. Then frame_start+frame_end in one cycle, followed by proto_valid and frame_end: exactly one record.
- Assert rst with 3 queued records and a staged one: m_valid=0, level=0, drop_cnt=0 asynchronously. After release, a new frame pushes normally.
